// File: rtl/av_arb_pkg.sv
// Shared types and constants for the FETCH Avalon master arbiter.
package av_arb_pkg;

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  localparam int unsigned TimeoutCyclesDefault = 255;

  // Avalon slave map of the FETCH system
  localparam logic [15:0] JTAG_UART_DATA = 16'h0100;
  localparam logic [15:0] JTAG_UART_CTRL = 16'h0104;
  localparam logic [15:0] LED_REG        = 16'h0200;

endpackage

// File: rtl/av_master_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the one not served last.
module rr_arbiter2
  import av_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/av_master_arbiter.sv
// Round-robin sequencer for the single Avalon-MM master port; one transfer at a time.
// Optional bus timeout enabled by defining AV_TIMEOUT_EN.
module av_master_arbiter
  import av_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_W-1:0]     av_address,
  output logic                  av_read,
  output logic                  av_write,
  output logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W-1:0]     av_readdata,
  input  logic                  av_waitrequest
);

  state_e              state_q;
  logic                last_grant_q;
  logic                grant_q;
  logic [1:0]          req_done_q;
  logic                av_read_q;
  logic                av_write_q;
  logic [ADDR_W-1:0]   av_address_q;
  logic [DATA_W-1:0]   av_writedata_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic                arb_grant;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                timed_out;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  assign sel_write = req_write[arb_grant];
  assign sel_addr  = arb_grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = arb_grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

`ifdef AV_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q;
  logic            rsp_error_q;

  // cnt_q counts stalled BUS edges already seen; abort on the last allowed one
  assign timed_out = av_waitrequest && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign rsp_error = rsp_error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
  assign rsp_error      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      req_done_q     <= '0;
      av_read_q      <= 1'b0;
      av_write_q     <= 1'b0;
      av_address_q   <= '0;
      av_writedata_q <= '0;
      rsp_rdata_q    <= '0;
`ifdef AV_TIMEOUT_EN
      cnt_q          <= '0;
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            grant_q        <= arb_grant;
            av_read_q      <= ~sel_write;
            av_write_q     <= sel_write;
            av_address_q   <= sel_addr;
            av_writedata_q <= sel_wdata;
`ifdef AV_TIMEOUT_EN
            cnt_q          <= '0;
`endif
            state_q        <= StBus;
          end
        end
        StBus: begin
          if (!av_waitrequest || timed_out) begin
            if (!av_waitrequest) begin
              if (av_read_q) rsp_rdata_q <= av_readdata;
            end else begin
              rsp_rdata_q <= '1;
            end
`ifdef AV_TIMEOUT_EN
            rsp_error_q  <= av_waitrequest;
`endif
            av_read_q    <= 1'b0;
            av_write_q   <= 1'b0;
            req_done_q   <= grant_q ? 2'b10 : 2'b01;
            last_grant_q <= grant_q;
            state_q      <= StDone;
          end
`ifdef AV_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          // requests are deliberately not sampled here so a just-served one cannot re-win
          req_done_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_done     = req_done_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign av_address   = av_address_q;
  assign av_read      = av_read_q;
  assign av_write     = av_write_q;
  assign av_writedata = av_writedata_q;

endmodule

// File: tb/tb_av_master_arbiter.sv
// Bench for av_master_arbiter: directed scenarios plus random traffic against a transfer-level model.
module tb_av_master_arbiter;
  import av_arb_pkg::*;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_done;
  logic [31:0] req_addr, req_wdata;
  logic [15:0] rsp_rdata, av_address, av_writedata, av_readdata;
  logic        rsp_error, av_read, av_write, av_waitrequest;

  av_master_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_done       (req_done),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .av_address     (av_address),
    .av_read        (av_read),
    .av_write       (av_write),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transfer-level model: an accepted transfer holds its strobe until the slave accepts
  // (or times out), the completion cycle carries the done pulse, and requests are only
  // taken when neither a transfer nor its completion cycle is in progress.
  bit          m_ready = 1'b0;
  bit          m_on;
  int          m_done;
  bit          m_last;
  int          m_owner;
  int          m_cnt;
  bit          m_write;
  logic [15:0] m_addr, m_wdata, m_rdata;
  bit          m_err;

  always @(posedge clk) begin : model
    int prev_done;
    if (reset) begin
      m_ready = 1'b1; m_on = 1'b0; m_done = -1; m_last = 1'b1; m_cnt = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_write = 1'b0; m_owner = 0;
    end else if (m_ready) begin
      prev_done = m_done;
      m_done = -1;
      if (m_on) begin
        m_cnt++;
        if (!av_waitrequest) begin
          if (!m_write) m_rdata = av_readdata;
          m_err = 1'b0; m_on = 1'b0; m_done = m_owner; m_last = (m_owner == 1);
        end
`ifdef AV_TIMEOUT_EN
        else if (m_cnt == TO) begin
          m_rdata = 16'hFFFF;
          m_err = 1'b1; m_on = 1'b0; m_done = m_owner; m_last = (m_owner == 1);
        end
`endif
      end else if (prev_done < 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) m_owner = m_last ? 0 : 1;
        else m_owner = req_valid[1] ? 1 : 0;
        m_write = req_write[m_owner];
        m_addr  = req_addr[m_owner*16 +: 16];
        m_wdata = req_wdata[m_owner*16 +: 16];
        m_on    = 1'b1;
        m_cnt   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("av_read", av_read, m_on && !m_write);
      check("av_write", av_write, m_on && m_write);
      check("req_done", req_done, (m_done == 0) ? 2'b01 : (m_done == 1) ? 2'b10 : 2'b00);
      check("rsp_rdata", rsp_rdata, m_rdata);
      if (m_on) begin
        check("av_address", av_address, m_addr);
        check("av_writedata", av_writedata, m_wdata);
      end
      if (m_done >= 0) check("rsp_error", rsp_error, m_err);
    end
  end

  // Random requesters and slave: a requester drops valid right after seeing its done.
  bit         rand_mode = 1'b0;
  logic [1:0] done_seen = 2'b00;

  always @(negedge clk) done_seen = req_done;

  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      for (int r = 0; r < 2; r++) begin
        if (done_seen[r]) req_valid[r] = 1'b0;
        else if (!req_valid[r] && $urandom_range(0, 2) == 0) req_valid[r] = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          req_write[r]           = 1'($urandom_range(0, 1));
          req_addr[r*16 +: 16]   = 16'($urandom);
          req_wdata[r*16 +: 16]  = 16'($urandom);
        end
      end
      av_waitrequest = ($urandom_range(0, 9) < 4);
      av_readdata    = 16'($urandom);
      reset          = ($urandom_range(0, 299) == 0);
    end
  end

  initial begin
    int n;
    bit got;
    bit prev_s, s;
    int rise[$];
    int rise_own[$];
    int done_ord[$];
    logic [1:0]  first_done;
    logic [15:0] first_addr;

    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    av_waitrequest = 1'b0; av_readdata = '0;
    step(); step();

    check("rst_req_done", req_done, 2'b00);
    check("rst_av_read", av_read, 1'b0);
    check("rst_av_write", av_write, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0000);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_av_address", av_address, 16'h0000);
    check("rst_av_writedata", av_writedata, 16'h0000);

    // single write, no stall
    reset = 1'b0;
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[15:0] = JTAG_UART_DATA; req_wdata[15:0] = 16'h0041;
    step();
    check("wr_strobe", av_write, 1'b1);
    check("wr_no_read", av_read, 1'b0);
    check("wr_addr", av_address, 16'h0100);
    check("wr_data", av_writedata, 16'h0041);
    check("wr_done_early", req_done, 2'b00);
    step();
    check("wr_strobe_off", av_write, 1'b0);
    check("wr_done", req_done, 2'b01);
    req_valid = 2'b00;
    step();
    check("wr_done_once", req_done, 2'b00);

    // stalled read from requester 1
    req_valid = 2'b10; req_write = 2'b00; req_addr[31:16] = JTAG_UART_CTRL;
    av_waitrequest = 1'b1; av_readdata = 16'hBEEF;
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (req_done != 2'b00) got = 1'b1;
      else begin
        if (av_read) n++;
        if (n == 6) av_waitrequest = 1'b0;
      end
    end
    check("rd_completed", got, 1'b1);
    check("rd_strobe_cycles", n, 6);
    check("rd_done", req_done, 2'b10);
    check("rd_rdata", rsp_rdata, 16'hBEEF);
    req_valid = 2'b00; av_waitrequest = 1'b0;
    step();
    check("rd_done_once", req_done, 2'b00);

    // tie from reset, then alternation
    reset = 1'b1; req_valid = 2'b11; req_write = 2'b11;
    req_addr = {16'h0020, 16'h0010};
    step();
    reset = 1'b0;
    prev_s = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      s = av_read | av_write;
      if (s && !prev_s) begin
        rise.push_back(c);
        rise_own.push_back((av_address == 16'h0020) ? 1 : 0);
      end
      prev_s = s;
      if (req_done == 2'b01) done_ord.push_back(0);
      else if (req_done == 2'b10) done_ord.push_back(1);
    end
    check("tie_enough_grants", (rise.size() >= 4 && done_ord.size() >= 4), 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k < rise.size()) check("tie_grant_order", rise_own[k], k % 2);
      if (k < done_ord.size()) check("tie_done_order", done_ord[k], k % 2);
      if (k > 0 && k < rise.size()) check("tie_spacing", rise[k] - rise[k-1], 3);
    end

    // reset during a stalled write
    reset = 1'b1; req_valid = 2'b00;
    step();
    reset = 1'b0; req_valid = 2'b01; req_write = 2'b01; av_waitrequest = 1'b1;
    step(); step();
    check("mid_strobe", av_write, 1'b1);
    reset = 1'b1;
    step();
    check("mid_rst_write", av_write, 1'b0);
    check("mid_rst_read", av_read, 1'b0);
    check("mid_rst_done", req_done, 2'b00);
    reset = 1'b0; req_valid = 2'b11; av_waitrequest = 1'b0;
    first_done = 2'b00; first_addr = '0;
    for (int i = 0; i < 10 && first_done == 2'b00; i++) begin
      step();
      if (av_write && first_addr == 16'h0000) first_addr = av_address;
      first_done = req_done;
    end
    check("mid_fresh_done", first_done, 2'b01);
    check("mid_fresh_addr", first_addr, 16'h0010);

    // slave never answers
    reset = 1'b1; req_valid = 2'b00;
    step();
    reset = 1'b0; req_valid = 2'b01; req_write = 2'b00; av_waitrequest = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      step();
      if (req_done != 2'b00) got = 1'b1;
      else if (av_read) n++;
    end
`ifdef AV_TIMEOUT_EN
    check("to_done_seen", got, 1'b1);
    check("to_bus_cycles", n, TO);
    check("to_done", req_done, 2'b01);
    check("to_error", rsp_error, 1'b1);
    check("to_rdata", rsp_rdata, 16'hFFFF);
`else
    check("noto_no_done", got, 1'b0);
    check("noto_still_reading", av_read, 1'b1);
`endif
    reset = 1'b1; req_valid = 2'b00; av_waitrequest = 1'b0;
    step();

    // random traffic checked by the model
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) step();
    rand_mode = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/av_master_arbiter.md
# av_master_arbiter

Two-requester arbiter and sequencer for the single Avalon-MM master port of the FETCH core on DE0-nano. Requester 0 is the CPU's register-mapped bus port (av_address/av_writedata/av_ctrl/av_waitrequest). Requester 1 is a secondary master, such as a debug loader or DMA. The block grants the bus round-robin, runs one non-pipelined read or write at a time to completion, and returns a one-cycle done pulse with read data.

## Interface
Parameters:
- ADDR_W, 16, Avalon address width
- DATA_W, 16, Avalon data width
- TIMEOUT_CYCLES, 255, maximum cycles spent in BUS before abort; used only when AV_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request; held high until that requester's req_done is seen
- req_write  in  2  1 = write, 0 = read; per requester
- req_addr  in  2*ADDR_W  packed addresses; requester r uses bits [r*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  packed write data, same packing as req_addr
- req_done  out  2  one-cycle completion pulse, one-hot to the granted requester
- rsp_rdata  out  DATA_W  read data; valid while req_done is high, held until the next completion
- rsp_error  out  1  timeout flag; valid while req_done is high
- av_address  out  ADDR_W  Avalon address
- av_read  out  1  Avalon read strobe
- av_write  out  1  Avalon write strobe
- av_writedata  out  DATA_W  Avalon write data
- av_readdata  in  DATA_W  Avalon read data; sampled in the cycle waitrequest is low
- av_waitrequest  in  1  Avalon stall

## Operation
- The state machine has three states: IDLE, BUS and DONE. The reset state is IDLE.
- **IDLE:**
  - If any req_valid bit is high, pick a grant g.
  - Latch req_write[g], req_addr[g] and req_wdata[g] into command registers.
  - Go to BUS. Otherwise stay in IDLE.
- **Arbitration:**
  - A single request is granted directly.
  - If both requests are valid, grant the requester that was not last granted.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates on entry to DONE.
- **BUS:**
  - av_read or av_write is asserted from the registers, with address and data stable.
  - On an edge where av_waitrequest=0: capture av_readdata into rsp_rdata (reads only), clear rsp_error, go to DONE.
  - For writes, rsp_rdata keeps its previous value.
- **DONE:**
  - req_done[g] = 1 for exactly one cycle, and both strobes are low.
  - Requests are not sampled in this state.
  - The next state is always IDLE.
- A requester deasserts req_valid at the edge where it sees req_done high. Because DONE skips sampling, a stale request cannot be re-granted.
- Changes to req_* inputs of the granted requester during BUS are ignored.
- Changes to req_* inputs of the other requester are ignored until IDLE.

## Timing
- **Reset values:**
  - State is IDLE and last_grant=1.
  - req_done, av_read, av_write, rsp_error and rsp_rdata are all 0.
  - av_address and av_writedata are 0.
- **Minimum latency:**
  - Request sampled at edge E0.
  - Strobe high in cycle E0..E1.
  - With waitrequest low at E1, req_done is high in cycle E1..E2.
  - Each extra cycle of waitrequest adds one cycle of latency.
- The two strobes are never high together. Neither strobe is ever high outside BUS.
- **Back-to-back requests:** the minimum spacing between strobe assertions is 3 cycles (BUS, DONE, IDLE).
- **Reset mid-transaction:** at the reset edge, the state returns to IDLE and strobes are low the following cycle. No req_done is issued for the aborted transfer.

## Configuration
- Macro AV_TIMEOUT_EN.
- **Defined:**
  - An 8-bit (or wider, per TIMEOUT_CYCLES) counter clears on entry to BUS and increments each BUS cycle.
  - If the count reaches TIMEOUT_CYCLES with waitrequest still high, drop the strobes and go to DONE.
  - In that DONE cycle, rsp_error=1 and rsp_rdata=all ones.
- **Not defined:**
  - There is no counter, and BUS waits indefinitely.
  - rsp_error is tied to 0.

## Structure
- Package av_arb_pkg holds:
  - the state enum (IDLE, BUS, DONE)
  - the default TIMEOUT_CYCLES
  - the Avalon slave address constants, e.g. JTAG_UART_DATA = 16'h0100
- Sub-module rr_arbiter2 is purely combinational. It takes the valid vector and last_grant and returns the grant index.

## Test plan
- **Single write:** requester 0 writes addr 16'h0100, data 16'h0041, with waitrequest low.
  - av_write is high for exactly 1 cycle with these values.
  - req_done[0] pulses 2 cycles after the request is sampled.
- **Stalled read:** requester 1 reads addr 16'h0104 with waitrequest high for 5 cycles and readdata 16'hBEEF.
  - av_read is high for 6 cycles.
  - rsp_rdata=16'hBEEF together with req_done[1].
- **Tie then alternate:** both requesters are continuously valid from reset.
  - Grant order is 0,1,0,1.
  - Strobe assertions are spaced exactly 3 cycles apart.
- **Reset mid-BUS:** assert reset during a stalled write.
  - Strobes are low the next cycle and no req_done is issued.
  - A fresh request afterwards completes normally and wins as requester 0.
- **Timeout (AV_TIMEOUT_EN defined):** waitrequest is held high forever.
  - After 255 BUS cycles, req_done pulses with rsp_error=1 and rsp_rdata=16'hFFFF.
  - Without the macro, no req_done is issued within 1000 cycles.
